// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter sharing one resource among N requesters.
// The winner search starts at a rotating pointer and scans downward, wrapping
// from 0 to N-1. One registered one-hot grant is held until the owner releases,
// and only a release moves the pointer.
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// owned cycles. With the macro undefined no hold counter is built and timeout
// is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among req from ptr downward
// OWN   | grant held; release on done, owner req drop, or forced timeout

module rr_req_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = $clog2(N),   // derived from N; leave at default
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    grant_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic            valid_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] win, cand;
  logic            found;
  logic            force_rel;
  logic            release_c;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          timeout_q, timeout_nxt;

  // Forced release fires on the last allowed owned cycle.
  assign force_rel = (state == OWN) && (hold_cnt == HW'(MAX_HOLD - 1));
  assign timeout   = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Owner release: done and a req drop in the same cycle are one release.
  assign release_c = done || !req[grant_idx] || force_rel;

  // Priority search starting at ptr, scanning downward with wrap to N-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDXW'((int'(ptr) + N - k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    valid_nxt = grant_valid;
    ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        // done is meaningless without an owner and is ignored here.
        if (found) begin
          state_nxt = OWN;
          grant_nxt = {{(N-1){1'b0}}, 1'b1} << win;
          idx_nxt   = win;
          valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end
      end
      OWN: begin
`ifdef ARB_TIMEOUT_EN
        hold_nxt = hold_cnt + 1'b1;
`endif
        if (release_c) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          idx_nxt   = '0;
          valid_nxt = 1'b0;
          // The released owner drops to lowest priority on the next search.
          ptr_nxt   = (grant_idx == '0) ? IDXW'(N - 1) : grant_idx - 1'b1;
`ifdef ARB_TIMEOUT_EN
          timeout_nxt = force_rel && !done && req[grant_idx];
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= IDXW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      ptr         <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= hold_nxt;
      timeout_q   <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter: directed bench for rr_req_arbiter (N=8). Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point.
// With ARB_TIMEOUT_EN defined the DUT is built with MAX_HOLD=4.

module tb_rr_req_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MH = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          timeout;

  int checks = 0;
  int errors = 0;

`ifdef ARB_TIMEOUT_EN
  rr_req_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
`else
  rr_req_arbiter #(.N(N)) dut (
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [N-1:0] g;
    g = '0;
    g[idx] = 1'b1;
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_idx"}, 32'(grant_idx), 32'd0);
    chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #3;
    chk_idle("reset");
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("idle_noreq");

    // 1: ptr starts at 7, so 7 beats 0; after release ptr=6 and 0 wins.
    req = 8'h81;
    tick();
    chk_grant("t1_first", 7);
    req = 8'h83;                      // non-owner change while owned
    tick();
    chk_grant("t1_hold", 7);
    req  = 8'h81;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_idle("t1_release");
    tick();
    chk_grant("t1_second", 0);
    req = '0;
    tick();                           // release of 0 -> ptr wraps to 7
    chk_idle("t1_drop");

    // 2: all requesting, done one cycle after each grant -> 7,6,...,0,7.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_grant("t2_rot", (15 - i) % 8);
      chk("t2_onehot", 32'($onehot(grant)), 32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("t2_rel");
    end
    req = '0;                         // ptr now 6
    tick();
    chk_idle("t2_quiet");

    // 3: owner drops req without done -> release, ptr=2, then 2 beats 3.
    req = 8'h08;
    tick();
    chk_grant("t3_own3", 3);
    req = 8'h00;
    tick();
    chk_idle("t3_drop");
    req = 8'h0C;
    tick();
    chk_grant("t3_own2", 2);
    req = '0;
    tick();                           // ptr now 1
    chk_idle("t3_rel");

    // 4: ptr=1 picks 0; async reset mid-grant restores ptr to 7.
    req = 8'h81;
    tick();
    chk_grant("t4_pre", 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t4_async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_grant("t4_post", 7);
    req = '0;
    tick();                           // ptr now 6
    chk_idle("t4_rel");

    // 6: stray done in IDLE is ignored; done+drop together is one release.
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_idle("t6_stray");
    req = 8'h02;
    tick();
    chk_grant("t6_own1", 1);
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_idle("t6_rel");
    req = 8'h03;                      // ptr=0 -> 0 wins over 1
    tick();
    chk_grant("t6_single_rel", 0);
    req = '0;
    tick();                           // ptr now 7
    chk_idle("t6_quiet");

    // 5: owner holds req with no done.
    req = 8'h10;
    tick();
    chk_grant("t5_first", 4);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < MH; i++) begin
      tick();
      chk("t5_hold_valid", 32'(grant_valid), 32'd1);
      chk("t5_hold_to", 32'(timeout), 32'd0);
    end
    tick();
    chk_idle("t5_forced");
    chk("t5_to_pulse", 32'(timeout), 32'd1);
    tick();
    chk_grant("t5_regrant", 4);
    chk("t5_to_clear", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 110; i++) begin
      tick();
      chk("t5_hold_valid", 32'(grant_valid), 32'd1);
      chk("t5_hold_to", 32'(timeout), 32'd0);
    end
    chk_grant("t5_still", 4);
`endif
    req = '0;
    tick();
    chk_idle("t5_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
